uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit stage downstream of the baud rate generator. Accepts one byte per valid/ready
//   handshake and serialises it onto tx as start, DATA_BITS data (LSB first), optional parity, stop.
//   Bit timing comes from rising edges of baud_clk, which is a same-domain square wave.
//   At 100 MHz / 9600 the baud generator gives one rising edge per 1302 clk = 8 edges per bit.
// PARAMETERS
//   TICKS_PER_BIT  8  baud_clk rising edges per serial bit (>=2)
//   DATA_BITS      8  data bits per frame (5..9)
//   PARITY_EN      0  1 = insert parity bit after data
//   PARITY_ODD     0  0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
//   STOP_BITS      1  number of stop bits (1 or 2)
// PORTS
//   clk       in   1          system clock, 100 MHz
//   reset_n   in   1          asynchronous reset, active-low
//   baud_clk  in   1          baud generator output, synchronous to clk
//   tx_data   in   DATA_BITS  byte to send; sampled on accept only
//   tx_valid  in   1          upstream has data
//   tx_ready  out  1          block can accept; accept = tx_valid & tx_ready at posedge clk
//   tx        out  1          serial line, idle high
//   tx_busy   out  1          frame in progress (state != IDLE)
//   tx_done   out  1          1-cycle pulse when the last stop bit completes
// BEHAVIOUR
//   Reset (async, reset_n=0) sets the following values:
//     tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE.
//     Tick counter, bit counter, shift register and baud_clk_q are all 0.
//   tick = baud_clk & ~baud_clk_q, where baud_clk_q is a 1-flop delay of baud_clk.
//     No synchroniser is needed because baud_clk is in the same clock domain.
//   All outputs are registered. tx never glitches between ticks.
//   States: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1, tx_ready=1.
//     On accept, latch tx_data into the shift register and compute the parity bit.
//     Next cycle: tx_ready=0, tx_busy=1, state=SYNC.
//   SYNC: wait for the next tick. On that tick, tx<=0 and state=START with tick count 0.
//     This aligns every bit to a tick boundary.
//     Latency from accept to the tx falling edge is 1 to TICKS_PER_BIT... at most one tick period + 1 clk.
//   In START, DATA, PARITY and STOP, each tick increments the tick count.
//     When the count reaches TICKS_PER_BIT-1, the next tick ends the bit and the count wraps to 0.
//     Each bit therefore lasts exactly TICKS_PER_BIT tick periods (10416 clk at defaults).
//   DATA: tx = shreg[0]. The shift register shifts right at each bit end.
//     The bit counter runs 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_EN=1, else STOP.
//   PARITY: tx = ^data, XORed with PARITY_ODD.
//   STOP: tx=1 for STOP_BITS bits. At the final bit end the following happen in the same cycle:
//     state=IDLE, tx_done=1 for 1 clk, tx_ready=1, tx_busy=0.
//   Back-to-back frames: if tx_valid is held, the next accept occurs in the first IDLE cycle.
//     SYNC then waits for the next tick, so the inter-frame idle is exactly 1 tick period.
//   tx_valid while tx_ready=0 is ignored; nothing is queued.
//     tx_data changes after accept do not affect the frame in flight.
//   If baud_clk stalls, the FSM and tx hold their values indefinitely; there is no timeout.
//   Reset mid-frame: tx returns to 1 immediately (asynchronously) and the frame is dropped.
//     No tx_done pulse is generated.
//   Widths: tick counter is $clog2(TICKS_PER_BIT); bit counter is $clog2(DATA_BITS).
//     Counters compare with ==. Illegal parameter values stop elaboration via a generate-time check.
// STRUCTURE
//   Shared package uart_pkg: state encoding localparams.
//     ST_IDLE, ST_SYNC, ST_START, ST_DATA, ST_PARITY, ST_STOP as a 3-bit encoding.
//     Also UART_OVERSAMPLE_TICKS=8.
//   Sub-module uart_tick_detect (clk, reset_n, baud_clk -> tick): registered rising-edge detector.
//     It is reused by the future receiver.
//   The top level contains the FSM, counters, shift register, parity and output registers.
// TESTING (baud generator at defaults; 1 bit = 10416 clk, 1 tick = 1302 clk)
//   1. Reset and idle.
//      Stimulus: hold reset_n=0 for 10 clk, release, tx_valid=0 for 30000 clk.
//      Expect: tx=1, tx_ready=1, tx_busy=0, and no tx_done pulse.
//   2. Basic frame.
//      Stimulus: send 0xA5 with PARITY_EN=0 and STOP_BITS=1.
//      Expect on tx: 0,1,0,1,0,0,1,0,1,1, each bit exactly 10416 clk.
//      Expect one tx_done pulse, with tx_ready=0 throughout the frame.
//   3. Parity.
//      Stimulus: PARITY_EN=1, PARITY_ODD=0, send 0x07.
//      Expect: parity bit = 1. With PARITY_ODD=1, parity bit = 0. Frame is 11 bits.
//   4. Back-to-back.
//      Stimulus: hold tx_valid, send 0x55 then 0x0F. Change tx_data mid-frame.
//      Expect: the second start bit begins 1302 clk after the first stop ends, and both bytes are intact.
//   5. Reset mid-frame.
//      Stimulus: assert reset_n=0 during data bit 3 of 0xFF.
//      Expect: tx=1 within the same clk. After release, 0x3C is sent cleanly.
//   6. Two stop bits.
//      Stimulus: STOP_BITS=2.
//      Expect: tx high for 20832 clk before tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and common constants for the TX and future RX paths.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_SYNC   = 3'd1;
    localparam logic [STATE_W-1:0] ST_START  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd5;

    localparam int unsigned UART_OVERSAMPLE_TICKS = 8;

endpackage

// File: rtl/uart_tick_detect.sv
// Registered rising-edge detector for the same-domain baud_clk square wave.
// Emits a one-clk tick per baud_clk rising edge, one clk after the edge is seen.
module uart_tick_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic baud_clk,
    output logic tick
);

    logic baud_clk_q;
    logic tick_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_clk_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            baud_clk_q <= baud_clk;
            tick_q     <= baud_clk & ~baud_clk_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per valid/ready handshake, sent as
// start, LSB-first data, optional parity and 1 or 2 stop bits, timed by baud ticks.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned TCW = $clog2(TICKS_PER_BIT);
    localparam int unsigned BCW = $clog2(DATA_BITS);

    generate
        if (TICKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
            STOP_BITS > 2 || PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_tx_serializer: illegal parameter value");
        end
    endgenerate

    logic [STATE_W-1:0]   state_q, state_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic tick;
    logic accept;
    logic bit_end;
    logic last_data;
    logic last_stop;

    uart_tick_detect u_tick_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    assign accept    = tx_valid & ready_q;
    assign bit_end   = tick & (tick_cnt_q == TCW'(TICKS_PER_BIT - 1));
    assign last_data = (bit_cnt_q == BCW'(DATA_BITS - 1));
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)  state_d = ST_SYNC;
            ST_SYNC:   if (tick)    state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && last_data) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values; tx follows the state being entered.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;

        if (state_q == ST_IDLE && accept) begin
            shreg_d  = tx_data;
            parity_d = (^tx_data) ^ 1'(PARITY_ODD);
        end
        if (tick && state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TCW'(1);
        end
        if (bit_end && state_q == ST_DATA) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = last_data ? '0 : bit_cnt_q + BCW'(1);
        end
        if (bit_end && state_q == ST_STOP) begin
            stop_cnt_d = last_stop ? 1'b0 : 1'b1;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = parity_q;
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a fast baud_clk (8 clk period, 1 bit = 64 clk).
// Four instances cover default, even parity, odd parity and two-stop-bit configurations.
module tb_uart_tx_serializer;

    localparam int BAUD_HALF = 4;
    localparam int BIT_CLKS  = 8 * 2 * BAUD_HALF;

    logic       clk;
    logic       reset_n;
    logic       baud_clk;
    logic [7:0] tx_data;
    logic [3:0] valid;
    logic [3:0] tx_w;
    logic [3:0] ready_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int vectors;
    int miscompares;

    uart_tx_serializer #(.TICKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_serializer #(.TICKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_serializer #(.TICKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx_serializer #(.TICKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_clk = 1'b0;
        forever begin
            repeat (BAUD_HALF) @(negedge clk);
            baud_clk = ~baud_clk;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
        $fatal(1);
    end

    task automatic start_frame(input int w, input logic [7:0] d);
        tx_data  = d;
        valid[w] = 1'b1;
        @(negedge clk);
        valid[w] = 1'b0;
    endtask

    // Waits for the start bit, then samples tx near both ends of every bit and times tx_done.
    task automatic capture_frame(input int w, input int nbits, output logic [15:0] early,
                                 output logic [15:0] late, output int lead, output int done_at,
                                 output logic hs_ok, output logic done_after, output logic tmo);
        early = '0; late = '0; lead = 0; done_at = -1;
        hs_ok = 1'b1; done_after = 1'b0; tmo = 1'b0;
        while (tx_w[w] !== 1'b0 && lead < 200) begin
            @(negedge clk);
            lead++;
        end
        if (lead >= 200) begin
            tmo = 1'b1;
            return;
        end
        for (int off = 0; off <= nbits * BIT_CLKS; off++) begin
            if (off < nbits * BIT_CLKS) begin
                if (off % BIT_CLKS == 1)            early[off / BIT_CLKS] = tx_w[w];
                if (off % BIT_CLKS == BIT_CLKS - 2) late[off / BIT_CLKS]  = tx_w[w];
                if (ready_w[w] !== 1'b0 || busy_w[w] !== 1'b1) hs_ok = 1'b0;
            end
            if (done_w[w] === 1'b1 && done_at < 0) done_at = off;
            @(negedge clk);
        end
        done_after = done_w[w];
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (tx_w !== 4'hF) begin miscompares++; $display("FAIL reset_tx got=%b required=1111", tx_w); end
        vectors++;
        if (ready_w !== 4'hF) begin miscompares++; $display("FAIL reset_ready got=%b required=1111", ready_w); end
        vectors++;
        if (busy_w !== 4'h0) begin miscompares++; $display("FAIL reset_busy got=%b required=0000", busy_w); end
        vectors++;
        if (done_w !== 4'h0) begin miscompares++; $display("FAIL reset_done got=%b required=0000", done_w); end
        reset_n = 1'b1;
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (tx_w !== 4'hF || ready_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL idle_stable bad_cycles got=%0d required=0", bad); end
    endtask

    task automatic test_basic_frame();
        logic [15:0] e, l;
        int lead, dat;
        logic hs, da, tmo;
        start_frame(0, 8'hA5);
        capture_frame(0, 10, e, l, lead, dat, hs, da, tmo);
        vectors++;
        if (tmo !== 1'b0) begin miscompares++; $display("FAIL basic_start timeout got=%b required=0", tmo); end
        // 0xA5 LSB first framed: 0,1,0,1,0,0,1,0,1,1
        vectors++;
        if (e !== 16'h034A) begin miscompares++; $display("FAIL basic_bits_early got=%h required=034a", e); end
        vectors++;
        if (l !== 16'h034A) begin miscompares++; $display("FAIL basic_bits_late got=%h required=034a", l); end
        vectors++;
        if (dat != 10 * BIT_CLKS) begin miscompares++; $display("FAIL basic_done_time got=%0d required=%0d", dat, 10 * BIT_CLKS); end
        vectors++;
        if (da !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got=%b required=0", da); end
        vectors++;
        if (hs !== 1'b1) begin miscompares++; $display("FAIL basic_ready_busy got=%b required=1", hs); end
        vectors++;
        if (lead < 1 || lead > 10) begin miscompares++; $display("FAIL basic_latency got=%0d required=1..10", lead); end
    endtask

    task automatic test_parity();
        logic [15:0] e, l;
        int lead, dat;
        logic hs, da, tmo;
        start_frame(1, 8'h07);
        capture_frame(1, 11, e, l, lead, dat, hs, da, tmo);
        // 0x07 even parity bit = 1
        vectors++;
        if (e !== 16'h060E || l !== 16'h060E || tmo !== 1'b0) begin
            miscompares++; $display("FAIL parity_even_bits got=%h/%h required=060e", e, l);
        end
        vectors++;
        if (dat != 11 * BIT_CLKS) begin miscompares++; $display("FAIL parity_even_done got=%0d required=%0d", dat, 11 * BIT_CLKS); end
        start_frame(2, 8'h07);
        capture_frame(2, 11, e, l, lead, dat, hs, da, tmo);
        // 0x07 odd parity bit = 0
        vectors++;
        if (e !== 16'h040E || l !== 16'h040E || tmo !== 1'b0) begin
            miscompares++; $display("FAIL parity_odd_bits got=%h/%h required=040e", e, l);
        end
        vectors++;
        if (dat != 11 * BIT_CLKS) begin miscompares++; $display("FAIL parity_odd_done got=%0d required=%0d", dat, 11 * BIT_CLKS); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e, l;
        int lead, dat;
        logic hs, da, tmo;
        tx_data  = 8'h55;
        valid[0] = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        capture_frame(0, 10, e, l, lead, dat, hs, da, tmo);
        valid[0] = 1'b0;
        tx_data  = 8'hFF;
        vectors++;
        if (e !== 16'h02AA || l !== 16'h02AA || tmo !== 1'b0) begin
            miscompares++; $display("FAIL b2b_first_bits got=%h/%h required=02aa", e, l);
        end
        vectors++;
        if (dat != 10 * BIT_CLKS) begin miscompares++; $display("FAIL b2b_first_done got=%0d required=%0d", dat, 10 * BIT_CLKS); end
        capture_frame(0, 10, e, l, lead, dat, hs, da, tmo);
        // One tick period (8 clk) from tx_done to the next start bit; one clk already elapsed.
        vectors++;
        if (lead != 7) begin miscompares++; $display("FAIL b2b_gap got=%0d required=7", lead); end
        vectors++;
        if (e !== 16'h021E || l !== 16'h021E || tmo !== 1'b0) begin
            miscompares++; $display("FAIL b2b_second_bits got=%h/%h required=021e", e, l);
        end
        vectors++;
        if (dat != 10 * BIT_CLKS) begin miscompares++; $display("FAIL b2b_second_done got=%0d required=%0d", dat, 10 * BIT_CLKS); end
        repeat (100) @(negedge clk);
        vectors++;
        if (busy_w[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_no_queue busy got=%b required=0", busy_w[0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] e, l;
        int lead, dat, n, pulses;
        logic hs, da, tmo;
        start_frame(0, 8'hFF);
        n = 0;
        while (tx_w[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * BIT_CLKS + 20) @(negedge clk);
        vectors++;
        if (busy_w[0] !== 1'b1 || n >= 200) begin miscompares++; $display("FAIL midreset_inflight busy got=%b required=1", busy_w[0]); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
            miscompares++; $display("FAIL midreset_async tx/busy/ready got=%b%b%b required=101", tx_w[0], busy_w[0], ready_w[0]);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0) pulses++;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL midreset_quiet bad_cycles got=%0d required=0", pulses); end
        start_frame(0, 8'h3C);
        capture_frame(0, 10, e, l, lead, dat, hs, da, tmo);
        vectors++;
        if (e !== 16'h0278 || l !== 16'h0278 || tmo !== 1'b0) begin
            miscompares++; $display("FAIL midreset_next_bits got=%h/%h required=0278", e, l);
        end
        vectors++;
        if (dat != 10 * BIT_CLKS) begin miscompares++; $display("FAIL midreset_next_done got=%0d required=%0d", dat, 10 * BIT_CLKS); end
    endtask

    task automatic test_two_stop();
        logic [15:0] e, l;
        int lead, dat;
        logic hs, da, tmo;
        start_frame(3, 8'hA5);
        capture_frame(3, 11, e, l, lead, dat, hs, da, tmo);
        vectors++;
        if (e !== 16'h074A || l !== 16'h074A || tmo !== 1'b0) begin
            miscompares++; $display("FAIL stop2_bits got=%h/%h required=074a", e, l);
        end
        vectors++;
        if (dat != 11 * BIT_CLKS) begin miscompares++; $display("FAIL stop2_done got=%0d required=%0d", dat, 11 * BIT_CLKS); end
        vectors++;
        if (hs !== 1'b1 || da !== 1'b0) begin miscompares++; $display("FAIL stop2_handshake hs/done_after got=%b%b required=10", hs, da); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        valid       = '0;
        tx_data     = '0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
